dbus_arbiter: RTL

DBUS_ARBITER -- requirements
Module: dbus_arbiter

---
 rtl/dbus_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dbus_arbiter.sv
// Data-bus arbiter: two masters share one data memory and one RSA accelerator window.
// Latency: ack on the 3rd cycle of a request for DMEM, plus one cycle per RSA wait-for-ack cycle.
// Backpressure: masters hold req until their one-cycle ack; RSA side stalls in place until rsa_ack.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   mN_req/addr/wdata/we  master N request (N=0,1); we==0 means read
//   mN_rdata/mN_ack       master N response, rdata valid only with ack
//   dmem_*                data-memory request, read data returns by the next edge
//   rsa_*                 RSA Wishbone-style request, held until rsa_ack
//   grant_id              master currently being served
//   bus_err               error pulse, coincident with the ack of a timed-out RSA access
//
// Optional feature: define DBUS_TIMEOUT_EN to bound the RSA wait to TIMEOUT_CYCLES cycles;
// a timed-out access completes with rdata 32'hDEAD_BEEF and bus_err=1.

module dbus_arbiter #(
    parameter logic [31:0] RSA_BASE       = 32'h0000_8000,
    parameter logic [31:0] RSA_MASK       = 32'hFFFF_FF00,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_we,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_we,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,

    output logic        dmem_en,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_we,
    input  logic [31:0] dmem_rdata,

    output logic        rsa_en,
    output logic [31:0] rsa_addr,
    output logic [31:0] rsa_wdata,
    output logic        rsa_we,
    input  logic [31:0] rsa_rdata,
    input  logic        rsa_ack,

    output logic        grant_id,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DMEM = 2'd1,
        S_RSA  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        prio_q,  prio_d;     // master that wins a simultaneous request
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  we_q,    we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;

    // Winner of the current IDLE sample: the priority holder on a tie, else the lone requester.
    logic        win;
    logic [31:0] sel_addr;
    assign win      = (m0_req && m1_req) ? prio_q : m1_req;
    assign sel_addr = win ? m1_addr : m0_addr;

    logic timeout_hit;

`ifdef DBUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;

    // Counts RSA cycles already spent; zero whenever outside RSA, so it is clear on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == S_RSA) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d = win;
                    prio_d  = ~win;
                    addr_d  = sel_addr;
                    wdata_d = win ? m1_wdata : m0_wdata;
                    we_d    = win ? m1_we    : m0_we;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ((sel_addr & RSA_MASK) == RSA_BASE) ? S_RSA : S_DMEM;
                end
            end
            S_DMEM: begin
                rdata_d = (|we_q) ? 32'h0 : dmem_rdata;
                state_d = S_RESP;
            end
            S_RSA: begin
                if (rsa_ack) begin
                    rdata_d = (|we_q) ? 32'h0 : rsa_rdata;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    rdata_d = 32'hDEAD_BEEF;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are gated by state so every bus reads zero while no transfer is active.
    logic in_dmem, in_rsa, in_resp;
    assign in_dmem = (state_q == S_DMEM);
    assign in_rsa  = (state_q == S_RSA);
    assign in_resp = (state_q == S_RESP);

    assign dmem_en    = in_dmem;
    assign dmem_addr  = in_dmem ? addr_q  : 32'h0;
    assign dmem_wdata = in_dmem ? wdata_q : 32'h0;
    assign dmem_we    = in_dmem ? we_q    : 4'h0;

    assign rsa_en     = in_rsa;
    assign rsa_addr   = in_rsa ? addr_q  : 32'h0;
    assign rsa_wdata  = in_rsa ? wdata_q : 32'h0;
    assign rsa_we     = in_rsa & (|we_q);

    assign m0_ack     = in_resp & ~grant_q;
    assign m1_ack     = in_resp &  grant_q;
    assign m0_rdata   = m0_ack ? rdata_q : 32'h0;
    assign m1_rdata   = m1_ack ? rdata_q : 32'h0;

    assign grant_id   = grant_q;
    assign bus_err    = in_resp & err_q;

endmodule
